// File: rtl/hazard3_irq_gateway_pkg.sv
// Shared definitions for the hazard3 external interrupt gateway.
// Holds the register map offsets, completion ID width and trigger encodings
// used by the gateway, the claim block and firmware-facing test code.
package hazard3_irq_gateway_pkg;

    // APB handshake phases: a single ready pulse per access, then wait for
    // the master to drop penable before accepting the next one.
    typedef enum logic [1:0] {
        APB_IDLE = 2'd0,
        APB_ACK  = 2'd1,
        APB_HOLD = 2'd2
    } apb_state_e;

    // Byte offsets of the configuration registers.
    localparam logic [7:0] REG_ENABLE   = 8'h00;
    localparam logic [7:0] REG_TRIGGER  = 8'h04;
    localparam logic [7:0] REG_PENDING  = 8'h08;
    localparam logic [7:0] REG_COMPLETE = 8'h0C;
    localparam logic [7:0] REG_RAW      = 8'h10;

    // COMPLETE carries a 1-based source ID in pwdata[IRQ_ID_W-1:0].
    localparam int IRQ_ID_W = 6;

    // TRIGGER register bit encodings.
    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/hazard3_irq_gateway_sync.sv
// N-wide two-flop synchronizer for asynchronous device interrupt lines.
// Only compiled when HAZARD3_IRQ_GW_SYNC_EN is defined; both stages reset to 0.
`ifdef HAZARD3_IRQ_GW_SYNC_EN
module hazard3_irq_sync #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta_q, meta_d;
    logic [N-1:0] sync_q, sync_d;

    // Next values: each stage takes the previous one.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Two synchronizer stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule
`endif

// File: rtl/hazard3_irq_gateway.sv
// Per-source external interrupt gateway feeding the claim block's irq bus.
// Sources are level or sticky edge requests, masked by a software enable;
// edge requests retire through PENDING W1C, COMPLETE(ID) or a TRIGGER change.
// Build option: define HAZARD3_IRQ_GW_SYNC_EN to pass src_i through a
// two-flop synchronizer before sampling (asynchronous devices).
module hazard3_irq_gateway
    import hazard3_irq_gateway_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int W_PADDR = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_PADDR-1:0] paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [N_SRC-1:0]   src_i,
    output logic [31:0]        irq
);

    apb_state_e       state_q, state_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] trigger_q, trigger_d;
    logic [N_SRC-1:0] pend_edge_q, pend_edge_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] s_q, s_d;
    logic [N_SRC-1:0] src_smp;
    logic [N_SRC-1:0] edge_clr;
    logic [N_SRC-1:0] pending;
    logic             commit;
    logic             wr_en;
    logic             unused_pwdata;

`ifdef HAZARD3_IRQ_GW_SYNC_EN
    hazard3_irq_sync #(
        .N (N_SRC)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (src_i),
        .q   (src_smp)
    );
`else
    assign src_smp = src_i;
`endif

    // APB handshake: commit on IDLE->ACK, then wait for penable to drop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (psel && penable) begin
                    state_d = APB_ACK;
                    commit  = 1'b1;
                end
            end
            APB_ACK:  state_d = APB_HOLD;
            APB_HOLD: begin
                if (!(psel && penable)) state_d = APB_IDLE;
            end
            default:  state_d = APB_IDLE;
        endcase
    end

    assign wr_en = commit && pwrite;

    // Register writes and edge request bookkeeping; a new edge beats any clear.
    always_comb begin
        enable_d  = enable_q;
        trigger_d = trigger_q;
        edge_clr  = '0;
        if (wr_en) begin
            if (paddr == W_PADDR'(REG_ENABLE)) begin
                enable_d = pwdata[N_SRC-1:0];
            end
            if (paddr == W_PADDR'(REG_TRIGGER)) begin
                trigger_d = pwdata[N_SRC-1:0];
                edge_clr  = trigger_q ^ pwdata[N_SRC-1:0];
            end
            if (paddr == W_PADDR'(REG_PENDING)) begin
                edge_clr = pwdata[N_SRC-1:0];
            end
            if (paddr == W_PADDR'(REG_COMPLETE)) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (pwdata[IRQ_ID_W-1:0] == IRQ_ID_W'(i + 1)) edge_clr[i] = 1'b1;
                end
            end
        end
        pend_edge_d = (pend_edge_q & ~edge_clr) | (s_q & ~prev_q);
        prev_d      = s_q;
        s_d         = src_smp;
    end

    // State register for the APB handshake, configuration and source path.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= APB_IDLE;
            enable_q    <= '0;
            trigger_q   <= {N_SRC{TRIG_LEVEL}};
            pend_edge_q <= '0;
            prev_q      <= '1;
            s_q         <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            trigger_q   <= trigger_d;
            pend_edge_q <= pend_edge_d;
            prev_q      <= prev_d;
            s_q         <= s_d;
        end
    end

    assign pending = (trigger_q & pend_edge_q) | (~trigger_q & s_q);
    assign irq     = 32'(pending & enable_q);
    assign pready  = (state_q == APB_ACK);
    assign pslverr = 1'b0;

    // Upper pwdata bits are don't-care for every register.
    assign unused_pwdata = ^pwdata;

    // Read data is a pure decode of paddr; unmapped offsets and COMPLETE read 0.
    always_comb begin
        prdata = '0;
        if (paddr == W_PADDR'(REG_ENABLE))       prdata = 32'(enable_q);
        else if (paddr == W_PADDR'(REG_TRIGGER)) prdata = 32'(trigger_q);
        else if (paddr == W_PADDR'(REG_PENDING)) prdata = 32'(pending);
        else if (paddr == W_PADDR'(REG_RAW))     prdata = 32'(s_q);
    end

endmodule

// File: tb/tb_hazard3_irq_gateway.sv
// Self-checking bench for hazard3_irq_gateway (N_SRC=8, W_PADDR=16).
// A queue-based reference model tracks sampled sources, edge requests and
// configuration, and irq is compared against it after every clock.
module tb_hazard3_irq_gateway;

`ifdef HAZARD3_IRQ_GW_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam logic [15:0] A_ENABLE   = 16'h00;
    localparam logic [15:0] A_TRIGGER  = 16'h04;
    localparam logic [15:0] A_PENDING  = 16'h08;
    localparam logic [15:0] A_COMPLETE = 16'h0C;
    localparam logic [15:0] A_RAW      = 16'h10;

    logic        clk;
    logic        rst;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  src_i;
    logic [31:0] irq;

    int total;
    int bad;

    // Reference model state.
    logic [7:0] m_en, m_trig, m_pend, m_prev, m_s;
    logic [7:0] m_pipe[$];

    hazard3_irq_gateway #(
        .N_SRC   (8),
        .W_PADDR (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .src_i   (src_i),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] model_pending();
        return (m_trig & m_pend) | (~m_trig & m_s);
    endfunction

    function automatic logic [31:0] model_irq();
        return {24'h0, model_pending() & m_en};
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a)
            A_ENABLE:  return {24'h0, m_en};
            A_TRIGGER: return {24'h0, m_trig};
            A_PENDING: return {24'h0, model_pending()};
            A_RAW:     return {24'h0, m_s};
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en   = '0;
        m_trig = '0;
        m_pend = '0;
        m_prev = '1;
        m_s    = '0;
        m_pipe.delete();
        for (int i = 0; i < LAT - 1; i++) m_pipe.push_back(8'h00);
    endtask

    // One clock edge of the model; wr means a write commits at this edge.
    task automatic model_step(input bit wr, input logic [15:0] a, input logic [31:0] d);
        logic [7:0] clr;
        logic [7:0] set;
        logic [7:0] new_s;
        int         id;
        clr = '0;
        m_pipe.push_back(src_i);
        new_s = m_pipe.pop_front();
        set = m_s & ~m_prev;
        if (wr) begin
            case (a)
                A_ENABLE:   m_en = d[7:0];
                A_TRIGGER:  begin clr = m_trig ^ d[7:0]; m_trig = d[7:0]; end
                A_PENDING:  clr = d[7:0];
                A_COMPLETE: begin
                    id = int'(d[5:0]);
                    if (id >= 1 && id <= 8) clr[id-1] = 1'b1;
                end
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | set;
        m_prev = m_s;
        m_s    = new_s;
    endtask

    task automatic tick(input bit wr, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(wr, a, d);
        #1;
        total++;
        if (irq !== model_irq()) begin
            bad++;
            $display("FAIL irq_track: got %h expected %h at %0t", irq, model_irq(), $time);
        end
    endtask

    // Full APB access; hold = number of cycles psel&penable stay high.
    task automatic apb_access(input bit wr, input logic [15:0] a, input logic [31:0] d,
                              input int hold, output logic [31:0] rd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick(1'b0, a, d);
        total++;
        if (pready !== 1'b0) begin bad++; $display("FAIL pready_setup: got %b expected 0", pready); end
        penable = 1'b1;
        tick(wr, a, d);
        total++;
        if (pready !== 1'b1) begin bad++; $display("FAIL pready_ack: got %b expected 1", pready); end
        rd = prdata;
        if (!wr) begin
            total++;
            if (prdata !== model_read(a)) begin
                bad++;
                $display("FAIL read_%h: got %h expected %h", a, prdata, model_read(a));
            end
        end
        for (int i = 1; i < hold; i++) begin
            tick(1'b0, a, d);
            total++;
            if (pready !== 1'b0) begin bad++; $display("FAIL pready_hold: got %b expected 0", pready); end
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, a, d);
            total++;
            if (pready !== 1'b0) begin bad++; $display("FAIL pready_drop: got %b expected 0", pready); end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1; src_i = 8'h01;
        idle(3);
        total++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            bad++; $display("FAIL reset_apb: got pready=%b pslverr=%b expected 0 0", pready, pslverr);
        end
        rst = 1'b0;
        idle(LAT + 3);
        total++;
        if (irq !== 32'h0) begin bad++; $display("FAIL reset_irq: got %h expected 0", irq); end
        apb_access(1'b0, A_TRIGGER, 32'h0, 1, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_trigger: got %h expected 0", rd); end
    endtask

    task automatic test_level();
        logic [31:0] rd;
        apb_access(1'b1, A_ENABLE, 32'h01, 1, rd);
        total++;
        if (irq !== 32'h1) begin bad++; $display("FAIL level_irq: got %h expected 1", irq); end
        apb_access(1'b0, A_RAW, 32'h0, 1, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL level_raw: got %h expected 1", rd); end
    endtask

    task automatic test_edge();
        logic [31:0] rd;
        src_i = 8'h00;
        idle(LAT + 2);
        apb_access(1'b1, A_TRIGGER, 32'h04, 1, rd);
        apb_access(1'b1, A_ENABLE,  32'h04, 1, rd);
        src_i = 8'h04;
        idle(1);
        src_i = 8'h00;
        idle(LAT + 3);
        total++;
        if (irq !== 32'h4) begin bad++; $display("FAIL edge_sticky: got %h expected 4", irq); end
        apb_access(1'b1, A_COMPLETE, 32'd3, 1, rd);
        total++;
        if (irq !== 32'h0) begin bad++; $display("FAIL edge_complete: got %h expected 0", irq); end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        // Time the rise so the edge is detected on the COMPLETE commit edge.
        src_i = 8'h04;
        idle(LAT - 1);
        apb_access(1'b1, A_COMPLETE, 32'd3, 1, rd);
        total++;
        if (irq !== 32'h4) begin bad++; $display("FAIL set_wins: got %h expected 4", irq); end
        src_i = 8'h00;
        apb_access(1'b1, A_COMPLETE, 32'd3, 1, rd);
        total++;
        if (irq !== 32'h0) begin bad++; $display("FAIL set_wins_clear: got %h expected 0", irq); end
    endtask

    task automatic test_complete_ignore();
        logic [31:0] rd;
        apb_access(1'b1, A_TRIGGER, 32'h01, 1, rd);
        apb_access(1'b1, A_ENABLE,  32'h01, 1, rd);
        src_i = 8'h01;
        idle(1);
        src_i = 8'h00;
        idle(LAT + 2);
        total++;
        if (irq !== 32'h1) begin bad++; $display("FAIL ign_pending: got %h expected 1", irq); end
        apb_access(1'b1, A_COMPLETE, 32'd0, 1, rd);
        total++;
        if (irq !== 32'h1) begin bad++; $display("FAIL ign_id0: got %h expected 1", irq); end
        apb_access(1'b1, A_COMPLETE, 32'd9, 1, rd);
        total++;
        if (irq !== 32'h1) begin bad++; $display("FAIL ign_id9: got %h expected 1", irq); end
        apb_access(1'b1, A_ENABLE, 32'h00, 1, rd);
        total++;
        if (irq !== 32'h0) begin bad++; $display("FAIL mask_off: got %h expected 0", irq); end
        apb_access(1'b0, A_PENDING, 32'h0, 1, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL mask_keeps: got %h expected 1", rd); end
        apb_access(1'b1, A_ENABLE, 32'h01, 1, rd);
        total++;
        if (irq !== 32'h1) begin bad++; $display("FAIL mask_reraise: got %h expected 1", irq); end
        apb_access(1'b1, A_PENDING, 32'h01, 1, rd);
        total++;
        if (irq !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h expected 0", irq); end
    endtask

    task automatic test_apb_hold();
        logic [31:0] rd;
        apb_access(1'b1, A_ENABLE, 32'h03, 3, rd);
        apb_access(1'b0, A_ENABLE, 32'h0, 1, rd);
        total++;
        if (rd !== 32'h3) begin bad++; $display("FAIL hold_write: got %h expected 3", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_ENABLE; pwdata = 32'hFF;
        tick(1'b0, A_ENABLE, 32'hFF);
        penable = 1'b1; rst = 1'b1;
        tick(1'b0, A_ENABLE, 32'hFF);
        total++;
        if (pready !== 1'b0) begin bad++; $display("FAIL midrst_pready: got %b expected 0", pready); end
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        idle(2);
        apb_access(1'b0, A_ENABLE, 32'h0, 1, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL midrst_discard: got %h expected 0", rd); end
    endtask

    task automatic test_latency();
        logic [31:0] rd;
        int          cnt;
        apb_access(1'b1, A_TRIGGER, 32'h00, 1, rd);
        apb_access(1'b1, A_ENABLE,  32'h01, 1, rd);
        src_i = 8'h00;
        idle(LAT + 3);
        src_i = 8'h01;
        cnt = 0;
        while (cnt < 9) begin
            tick(1'b0, 16'h0, 32'h0);
            cnt++;
            if (irq[0] === 1'b1) break;
        end
        total++;
        if (cnt != LAT) begin bad++; $display("FAIL latency: got %0d cycles expected %0d", cnt, LAT); end
        src_i = 8'h00;
        idle(LAT + 1);
    endtask

    task automatic test_random();
        logic [15:0] addrs[6];
        logic [31:0] rd;
        logic [31:0] d;
        int          sel;
        addrs = '{A_ENABLE, A_TRIGGER, A_PENDING, A_COMPLETE, A_RAW, 16'h14};
        for (int it = 0; it < 250; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                src_i = 8'($urandom);
                idle(1);
            end else begin
                paddr = addrs[$urandom_range(0, 5)];
                if (paddr == A_COMPLETE) d = 32'($urandom_range(0, 15));
                else                     d = {$urandom_range(0, 16'hFFFF), 8'($urandom), 8'($urandom)};
                apb_access(sel < 8, paddr, d, int'($urandom_range(1, 3)), rd);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; src_i = '0;
        model_reset();
        test_reset();
        test_level();
        test_edge();
        test_set_wins();
        test_complete_ignore();
        test_apb_hold();
        test_reset_mid();
        test_latency();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
